// File: rtl/fir_stream_driver.sv
// Initiator for the fir_filter load_coeff/data_ready/modwait handshake.
// Loads four coefficients, then streams samples through the filter one at a time.
module fir_stream_driver #(
  parameter int DATA_W      = 16,
  parameter int LC_PULSE    = 2,
  parameter int TIMEOUT_CYC = 25
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_start,
  input  logic [4*DATA_W-1:0] cfg_coeffs,
  output logic                coeffs_loaded,
  input  logic                in_valid,
  input  logic [DATA_W-1:0]   in_sample,
  output logic                in_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_err,
  output logic                out_one_k,
  output logic                timeout,
  output logic [DATA_W-1:0]   fir_sample_data,
  output logic [DATA_W-1:0]   fir_coefficient,
  output logic                fir_data_ready,
  output logic                fir_load_coeff,
  input  logic                fir_modwait,
  input  logic [DATA_W-1:0]   fir_out,
  input  logic                fir_err,
  input  logic                fir_one_k
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + LC_PULSE + 1);

  typedef enum logic [2:0] {
    IDLE, C_PULSE, C_WAIT, S_DRIVE, S_BUSY, S_CAPT, RESULT
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] coeff [4];
  logic [1:0]        idx;
  logic [1:0]        next_idx;
  logic [CNT_W-1:0]  cnt;
  logic              modwait_q;
  logic              mw_rise;
  logic              mw_fall;
  logic              wait_expired;

  assign mw_rise      = fir_modwait & ~modwait_q;
  assign mw_fall      = ~fir_modwait & modwait_q;
  assign next_idx     = idx + 2'd1;
  assign wait_expired = (cnt == CNT_W'(TIMEOUT_CYC - 1));

  // cfg_start has priority over a sample handshake in the same cycle
  assign in_ready = (state == IDLE) & coeffs_loaded & ~cfg_start;

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      for (int k = 0; k < 4; k++) coeff[k] <= '0;
      idx             <= 2'd0;
      cnt             <= '0;
      modwait_q       <= 1'b0;
      coeffs_loaded   <= 1'b0;
      timeout         <= 1'b0;
      out_valid       <= 1'b0;
      out_data        <= '0;
      out_err         <= 1'b0;
      out_one_k       <= 1'b0;
      fir_sample_data <= '0;
      fir_coefficient <= '0;
      fir_data_ready  <= 1'b0;
      fir_load_coeff  <= 1'b0;
    end else begin
      modwait_q <= fir_modwait;
      case (state)
        IDLE: begin
          if (cfg_start) begin
            for (int k = 0; k < 4; k++) coeff[k] <= cfg_coeffs[k*DATA_W +: DATA_W];
            idx             <= 2'd0;
            cnt             <= '0;
            timeout         <= 1'b0;
            coeffs_loaded   <= 1'b0;
            fir_coefficient <= cfg_coeffs[DATA_W-1:0];
            fir_load_coeff  <= 1'b1;
            state           <= C_PULSE;
          end else if (in_valid && coeffs_loaded) begin
            fir_sample_data <= in_sample;
            fir_data_ready  <= 1'b1;
            cnt             <= '0;
            state           <= S_DRIVE;
          end
        end
        C_PULSE: begin
          if (cnt == CNT_W'(LC_PULSE - 1)) begin
            fir_load_coeff <= 1'b0;
            cnt            <= '0;
            state          <= C_WAIT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        C_WAIT: begin
          if (mw_fall) begin
            cnt <= '0;
            if (idx == 2'd3) begin
              coeffs_loaded <= 1'b1;
              state         <= IDLE;
            end else begin
              idx             <= next_idx;
              fir_coefficient <= coeff[next_idx];
              fir_load_coeff  <= 1'b1;
              state           <= C_PULSE;
            end
          end else if (wait_expired) begin
            timeout <= 1'b1;
            state   <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_DRIVE: begin
          if (mw_rise) begin
            fir_data_ready <= 1'b0;
            cnt            <= '0;
            state          <= S_BUSY;
          end else if (wait_expired) begin
            timeout        <= 1'b1;
            fir_data_ready <= 1'b0;
            state          <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_BUSY: begin
          if (mw_fall) begin
            cnt   <= '0;
            state <= S_CAPT;
          end else if (wait_expired) begin
            timeout <= 1'b1;
            state   <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        // One settle cycle after modwait falls before the result is sampled
        S_CAPT: begin
          out_data  <= fir_out;
          out_err   <= fir_err;
          out_one_k <= fir_one_k;
          out_valid <= 1'b1;
          state     <= RESULT;
        end
        RESULT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          fir_data_ready <= 1'b0;
          fir_load_coeff <= 1'b0;
          out_valid      <= 1'b0;
          state          <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_stream_driver.sv
// Directed bench for fir_stream_driver with a small behavioural fir_filter responder.
module tb_fir_stream_driver;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cfg_start = 1'b0;
  logic [4*DW-1:0] cfg_coeffs = '0;
  logic          coeffs_loaded;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_sample = '0;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_err;
  logic          out_one_k;
  logic          timeout;
  logic [DW-1:0] fir_sample_data;
  logic [DW-1:0] fir_coefficient;
  logic          fir_data_ready;
  logic          fir_load_coeff;
  logic          fir_modwait;
  logic [DW-1:0] fir_out = '0;
  logic          fir_err = 1'b0;
  logic          fir_one_k = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fir_stream_driver dut (
    .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_coeffs(cfg_coeffs),
    .coeffs_loaded(coeffs_loaded), .in_valid(in_valid), .in_sample(in_sample),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err), .out_one_k(out_one_k), .timeout(timeout),
    .fir_sample_data(fir_sample_data), .fir_coefficient(fir_coefficient),
    .fir_data_ready(fir_data_ready), .fir_load_coeff(fir_load_coeff),
    .fir_modwait(fir_modwait), .fir_out(fir_out), .fir_err(fir_err), .fir_one_k(fir_one_k)
  );

  // Filter responder: modwait high 4 cycles per coefficient or sample; result from a table.
  logic          mw_dead = 1'b0;
  logic          m_mw = 1'b0;
  logic          m_busy = 1'b0;
  logic          m_lc_q = 1'b0;
  int            m_cnt = 0;
  int            m_count = 0;
  int            lc_run = 0;
  int            lc_pulses = 0;
  int            lc_bad = 0;
  int            coef_n = 0;
  logic [DW-1:0] coeff_got [4];
  logic [DW-1:0] last_sample = '0;
  logic [16:0]   resp [32];
  int            wr_i = 0;
  int            rd_i = 0;

  assign fir_modwait = m_mw & ~mw_dead;

  always @(posedge clk) begin
    if (reset) begin
      m_mw <= 1'b0; m_busy <= 1'b0; m_cnt <= 0; m_lc_q <= 1'b0; m_count <= 0; lc_run <= 0;
      fir_out <= '0; fir_err <= 1'b0; fir_one_k <= 1'b0;
    end else begin
      m_lc_q <= fir_load_coeff;
      if (fir_load_coeff) lc_run <= lc_run + 1;
      else if (m_lc_q) begin
        lc_pulses <= lc_pulses + 1;
        if (lc_run != 2) lc_bad <= lc_bad + 1;
        lc_run <= 0;
      end
      if (m_busy) begin
        if (m_cnt == 0) begin m_mw <= 1'b0; m_busy <= 1'b0; end
        else m_cnt <= m_cnt - 1;
      end else if (!mw_dead && fir_load_coeff && !m_lc_q) begin
        coeff_got[coef_n % 4] <= fir_coefficient;
        coef_n <= coef_n + 1;
        m_mw <= 1'b1; m_busy <= 1'b1; m_cnt <= 3;
      end else if (!mw_dead && fir_data_ready) begin
        last_sample <= fir_sample_data;
        m_count <= m_count + 1;
        fir_one_k <= (m_count + 1 >= 1000);
        if (rd_i != wr_i) begin
          fir_out <= resp[rd_i % 32][15:0];
          fir_err <= resp[rd_i % 32][16];
          rd_i <= rd_i + 1;
        end else begin
          fir_out <= '0;
          fir_err <= 1'b0;
        end
        m_mw <= 1'b1; m_busy <= 1'b1; m_cnt <= 3;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_coeffs(input logic [4*DW-1:0] c);
    int p0;
    int b0;
    p0 = lc_pulses;
    b0 = lc_bad;
    cfg_coeffs = c;
    cfg_start  = 1'b1;
    in_valid   = 1'b1;
    #1;
    check("cfg_prio_in_ready", in_ready, 1'b0);
    tick();
    cfg_start = 1'b0;
    in_valid  = 1'b0;
    check("cfg_clr_timeout", timeout, 1'b0);
    check("cfg_clr_loaded", coeffs_loaded, 1'b0);
    check("cfg_no_sample", fir_data_ready, 1'b0);
    for (int i = 0; i < 300 && !coeffs_loaded; i++) tick();
    tick();
    check("loaded", coeffs_loaded, 1'b1);
    check("lc_pulses", lc_pulses - p0, 4);
    check("lc_width_bad", lc_bad - b0, 0);
    for (int k = 0; k < 4; k++) check($sformatf("coeff%0d", k), coeff_got[k], c[k*DW +: DW]);
    check("load_timeout", timeout, 1'b0);
    check("load_in_ready", in_ready, 1'b1);
  endtask

  task automatic send(input logic [DW-1:0] s, input logic [DW-1:0] d, input logic e,
                      input logic k, input int hold);
    resp[wr_i % 32] = {e, d};
    wr_i++;
    for (int i = 0; i < 100 && !in_ready; i++) tick();
    check("in_ready", in_ready, 1'b1);
    in_valid  = 1'b1;
    in_sample = s;
    tick();
    in_valid = 1'b0;
    check("dr_on", fir_data_ready, 1'b1);
    check("smp_bus", fir_sample_data, s);
    for (int i = 0; i < 100 && !out_valid; i++) tick();
    check("out_valid", out_valid, 1'b1);
    check("out_data", out_data, d);
    check("out_err", out_err, e);
    check("out_one_k", out_one_k, k);
    check("filter_sample", last_sample, s);
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_valid", out_valid, 1'b1);
      check("hold_data", out_data, d);
      check("hold_in_ready", in_ready, 1'b0);
      check("hold_no_dr", fir_data_ready, 1'b0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("out_released", out_valid, 1'b0);
  endtask

  logic [4*DW-1:0] coefs = {16'h4000, 16'h8000, 16'h8000, 16'h4000};
  logic [DW-1:0]   t_s [8] = '{16'd1000, 16'd1000, 16'd100, 16'd100,
                               16'd65000, 16'd0, 16'd65000, 16'd0};
  logic [DW-1:0]   t_d [8] = '{16'd500, 16'd450, 16'd50, 16'd50,
                               16'd32500, 16'hFFFF, 16'd0, 16'd32500};
  logic            t_e [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    #200_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic seen;
    repeat (3) tick();
    in_valid = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_loaded", coeffs_loaded, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_timeout", timeout, 1'b0);
    check("rst_lc", fir_load_coeff, 1'b0);
    check("rst_dr", fir_data_ready, 1'b0);
    reset = 1'b0;
    tick();
    check("no_cfg_in_ready", in_ready, 1'b0);
    check("no_cfg_dr", fir_data_ready, 1'b0);
    in_valid = 1'b0;

    load_coeffs(coefs);
    for (int i = 0; i < 8; i++) send(t_s[i], t_d[i], t_e[i], 1'b0, 0);

    // Dead filter: data_ready must give up after the wait budget
    mw_dead = 1'b1;
    in_valid  = 1'b1;
    in_sample = 16'd777;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (fir_data_ready && n < 100) begin n++; tick(); end
    check("to_dr_cycles", n, 25);
    check("to_flag", timeout, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin seen = seen | out_valid; tick(); end
    check("to_no_result", seen, 1'b0);
    check("to_in_ready", in_ready, 1'b1);
    mw_dead = 1'b0;
    load_coeffs(coefs);

    send(16'd1234, 16'd4321, 1'b0, 1'b0, 6);

    // Reset while the filter is busy
    resp[wr_i % 32] = {1'b0, 16'd123};
    wr_i++;
    in_valid  = 1'b1;
    in_sample = 16'd55;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 50 && fir_data_ready; i++) tick();
    check("busy_mw", fir_modwait, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_out_data", out_data, 16'd0);
    check("mid_out_valid", out_valid, 1'b0);
    check("mid_loaded", coeffs_loaded, 1'b0);
    check("mid_coef_bus", fir_coefficient, 16'd0);
    check("mid_smp_bus", fir_sample_data, 16'd0);
    check("mid_dr", fir_data_ready, 1'b0);
    check("mid_lc", fir_load_coeff, 1'b0);
    in_valid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin seen = seen | in_ready | fir_data_ready; tick(); end
    in_valid = 1'b0;
    check("mid_need_cfg", seen, 1'b0);
    load_coeffs(coefs);
    for (int i = 1; i <= 1002; i++) send(16'd0, 16'd0, 1'b0, (i >= 1000), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
